// File: rtl/core_seq_ctrl.sv
`timescale 1ns/1ps
// Per-kij sequencer for one core: weight fill, L0 write, PE load, execute, psum drain.
// Every output is registered; each phase advances on counters, and DRAIN waits on ofifo_valid.
module core_seq_ctrl #(
  parameter int BW       = 4,
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16,
  parameter int ADDR_W   = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [3:0]          kij,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [BW*ROW-1:0]   w_data,
  output logic [BW*ROW-1:0]   weight_data_in,
  output logic                weight_sram_cen,
  output logic                weight_sram_wen,
  output logic [ADDR_W-1:0]   weight_addr,
  output logic                l0_wr,
  output logic                l0_rd,
  output logic                load,
  output logic                mac_array_en,
  output logic                act_sram_cen,
  output logic                act_sram_wen,
  output logic [ADDR_W-1:0]   act_addr,
  input  logic                ofifo_valid,
  output logic                ofifo_rd,
  output logic                psum_sram_cen,
  output logic                psum_sram_wen,
  output logic [ADDR_W-1:0]   psum_addr
);

  localparam int CNT_W = $clog2(LEN_NIJ + COL + ROW + LEN_ONIJ + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_L0WR, S_PELOAD, S_EXEC, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d, wcnt, wcnt_d;
  logic [ADDR_W-1:0]   psum_base, psum_base_d;
  logic [3:0]          kij_d;
  logic                busy_d, done_d, w_ready_d;
  logic [BW*ROW-1:0]   wdata_d;
  logic                w_cen_d, w_wen_d, a_cen_d, a_wen_d, p_cen_d, p_wen_d;
  logic [ADDR_W-1:0]   w_addr_d, a_addr_d, p_addr_d;
  logic                l0_wr_d, l0_rd_d, load_d, mac_en_d, ofifo_rd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      wcnt            <= '0;
      psum_base       <= '0;
      kij             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      w_ready         <= 1'b0;
      weight_data_in  <= '0;
      weight_sram_cen <= 1'b1;
      weight_sram_wen <= 1'b1;
      weight_addr     <= '0;
      l0_wr           <= 1'b0;
      l0_rd           <= 1'b0;
      load            <= 1'b0;
      mac_array_en    <= 1'b0;
      act_sram_cen    <= 1'b1;
      act_sram_wen    <= 1'b1;
      act_addr        <= '0;
      ofifo_rd        <= 1'b0;
      psum_sram_cen   <= 1'b1;
      psum_sram_wen   <= 1'b1;
      psum_addr       <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      wcnt            <= wcnt_d;
      psum_base       <= psum_base_d;
      kij             <= kij_d;
      busy            <= busy_d;
      done            <= done_d;
      w_ready         <= w_ready_d;
      weight_data_in  <= wdata_d;
      weight_sram_cen <= w_cen_d;
      weight_sram_wen <= w_wen_d;
      weight_addr     <= w_addr_d;
      l0_wr           <= l0_wr_d;
      l0_rd           <= l0_rd_d;
      load            <= load_d;
      mac_array_en    <= mac_en_d;
      act_sram_cen    <= a_cen_d;
      act_sram_wen    <= a_wen_d;
      act_addr        <= a_addr_d;
      ofifo_rd        <= ofifo_rd_d;
      psum_sram_cen   <= p_cen_d;
      psum_sram_wen   <= p_wen_d;
      psum_addr       <= p_addr_d;
    end
  end

  // Outputs are computed one cycle early so that every pin leaves a flop.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wcnt_d      = wcnt;
    kij_d       = kij;
    psum_base_d = psum_base;
    busy_d      = busy;
    done_d      = 1'b0;
    w_ready_d   = 1'b0;
    wdata_d     = weight_data_in;
    w_cen_d     = 1'b1;
    w_wen_d     = 1'b1;
    w_addr_d    = weight_addr;
    l0_wr_d     = 1'b0;
    l0_rd_d     = 1'b0;
    load_d      = 1'b0;
    mac_en_d    = 1'b0;
    a_cen_d     = 1'b1;
    a_wen_d     = 1'b1;
    a_addr_d    = act_addr;
    ofifo_rd_d  = 1'b0;
    p_cen_d     = 1'b1;
    p_wen_d     = 1'b1;
    p_addr_d    = psum_addr;

    if (abort && state != S_IDLE) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      wcnt_d      = '0;
      kij_d       = '0;
      psum_base_d = '0;
      busy_d      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d     = S_WLOAD;
            busy_d      = 1'b1;
            w_ready_d   = 1'b1;
            cnt_d       = '0;
            wcnt_d      = '0;
            kij_d       = '0;
            psum_base_d = '0;
          end
        end
        S_WLOAD: begin
          w_ready_d = 1'b1;
          if (w_valid && w_ready) begin
            w_cen_d  = 1'b0;
            w_wen_d  = 1'b0;
            w_addr_d = ADDR_W'(cnt);
            wdata_d  = w_data;
            if (cnt == CNT_W'(COL - 1)) begin
              cnt_d     = '0;
              w_ready_d = 1'b0;
              state_d   = S_L0WR;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        S_L0WR: begin
          // l0_wr trails the read by one cycle to match SRAM read latency.
          if (cnt < CNT_W'(COL)) begin
            w_cen_d  = 1'b0;
            w_addr_d = ADDR_W'(cnt);
          end
          l0_wr_d = (cnt != '0);
          if (cnt == CNT_W'(COL)) begin
            cnt_d   = '0;
            state_d = S_PELOAD;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_PELOAD: begin
          load_d  = 1'b1;
          l0_rd_d = 1'b1;
          if (cnt == CNT_W'(ROW - 1)) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt < CNT_W'(LEN_NIJ)) begin
            a_cen_d  = 1'b0;
            a_addr_d = ADDR_W'(cnt);
          end
          mac_en_d = (cnt != '0);
          if (cnt == CNT_W'(LEN_NIJ)) begin
            cnt_d   = '0;
            wcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // cnt counts pops, wcnt counts psum writes (one cycle behind pops).
          if (ofifo_valid && cnt < CNT_W'(LEN_ONIJ)) begin
            ofifo_rd_d = 1'b1;
            cnt_d      = cnt + 1'b1;
          end
          if (ofifo_rd) begin
            p_cen_d  = 1'b0;
            p_wen_d  = 1'b0;
            p_addr_d = psum_base + ADDR_W'(wcnt);
            if (wcnt == CNT_W'(LEN_ONIJ - 1)) begin
              state_d = S_NEXT;
            end else begin
              wcnt_d = wcnt + 1'b1;
            end
          end
        end
        S_NEXT: begin
          cnt_d  = '0;
          wcnt_d = '0;
          if (kij == 4'(LEN_KIJ - 1)) begin
            state_d = S_DONE;
          end else begin
            kij_d       = kij + 1'b1;
            psum_base_d = psum_base + ADDR_W'(LEN_ONIJ);
            w_ready_d   = 1'b1;
            state_d     = S_WLOAD;
          end
        end
        S_DONE: begin
          done_d      = 1'b1;
          busy_d      = 1'b0;
          kij_d       = '0;
          psum_base_d = '0;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for core_seq_ctrl: replays per-edge stimulus tables and compares every edge
// against a timeline model built from the phase lengths of a pass.
module tb_core_seq_ctrl;
  localparam int BW = 4, ROW = 8, COL = 8, LEN_KIJ = 9, LEN_NIJ = 36, LEN_ONIJ = 16, ADDR_W = 11;
  localparam int DW = BW * ROW;
  localparam int MAXE = 4096;
  localparam int NPSUM = LEN_KIJ * LEN_ONIJ;

  logic clk = 1'b0;
  logic reset, start, abort, w_valid, ofifo_valid;
  logic [DW-1:0] w_data;
  logic busy, done, w_ready, l0_wr, l0_rd, load, mac_array_en, ofifo_rd;
  logic [3:0] kij;
  logic [DW-1:0] weight_data_in;
  logic weight_sram_cen, weight_sram_wen, act_sram_cen, act_sram_wen, psum_sram_cen, psum_sram_wen;
  logic [ADDR_W-1:0] weight_addr, act_addr, psum_addr;

  core_seq_ctrl #(.BW(BW), .ROW(ROW), .COL(COL), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ),
                  .LEN_ONIJ(LEN_ONIJ), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done), .kij(kij),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .weight_data_in(weight_data_in),
    .weight_sram_cen(weight_sram_cen), .weight_sram_wen(weight_sram_wen), .weight_addr(weight_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .load(load), .mac_array_en(mac_array_en),
    .act_sram_cen(act_sram_cen), .act_sram_wen(act_sram_wen), .act_addr(act_addr),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .psum_sram_cen(psum_sram_cen), .psum_sram_wen(psum_sram_wen), .psum_addr(psum_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done; logic [3:0] kij; logic w_ready;
    logic wcen, wwen; logic [ADDR_W-1:0] waddr; logic [DW-1:0] wdata;
    logic l0_wr, l0_rd, load, mac;
    logic acen, awen; logic [ADDR_W-1:0] aaddr;
    logic ofifo_rd, pcen, pwen; logic [ADDR_W-1:0] paddr;
  } obs_t;

  logic          st_a[MAXE], ab_a[MAXE], wv_a[MAXE], ov_a[MAXE];
  logic [DW-1:0] wd_a[MAXE];
  obs_t          exp_a[MAXE], act_a[MAXE];
  int pass_cnt = 0, chk_cnt = 0;

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.wcen = 1'b1; o.wwen = 1'b1; o.acen = 1'b1; o.awen = 1'b1; o.pcen = 1'b1; o.pwen = 1'b1;
    return o;
  endfunction

  function automatic obs_t busy_obs(input int k);
    obs_t o = idle_obs();
    o.busy = 1'b1; o.kij = 4'(k);
    return o;
  endfunction

  // Addresses and data are only meaningful while their SRAM is enabled.
  function automatic obs_t mask(input obs_t o);
    obs_t m = o;
    if (m.wcen) m.waddr = '0;
    if (m.wcen || m.wwen) m.wdata = '0;
    if (m.acen) m.aaddr = '0;
    if (m.pcen) m.paddr = '0;
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.kij = kij; o.w_ready = w_ready;
    o.wcen = weight_sram_cen; o.wwen = weight_sram_wen; o.waddr = weight_addr; o.wdata = weight_data_in;
    o.l0_wr = l0_wr; o.l0_rd = l0_rd; o.load = load; o.mac = mac_array_en;
    o.acen = act_sram_cen; o.awen = act_sram_wen; o.aaddr = act_addr;
    o.ofifo_rd = ofifo_rd; o.pcen = psum_sram_cen; o.pwen = psum_sram_wen; o.paddr = psum_addr;
    return o;
  endfunction

  function automatic int first_diff(input int n);
    for (int e = 0; e < n && e < MAXE; e++)
      if (act_a[e] !== mask(exp_a[e])) return e;
    return -1;
  endfunction

  // Timeline of one pass starting at edge s: 8 accepted words, 9 L0 cycles, 8 load cycles,
  // 37 execute cycles, a drain of 16 pops each followed by a write, one advance edge.
  task automatic model(input int s, output int done_e);
    obs_t o; int e; int acc; int pops; int writes; logic pend;
    e = s;
    o = busy_obs(0); o.w_ready = 1'b1; exp_a[e] = o;
    for (int k = 0; k < LEN_KIJ; k++) begin
      acc = 0;
      while (acc < COL && e < MAXE - 1) begin
        e++; o = busy_obs(k); o.w_ready = 1'b1;
        if (wv_a[e]) begin
          o.wcen = 1'b0; o.wwen = 1'b0; o.waddr = ADDR_W'(acc); o.wdata = wd_a[e]; acc++;
          if (acc == COL) o.w_ready = 1'b0;
        end
        exp_a[e] = o;
      end
      for (int i = 0; i <= COL; i++) begin
        e++; o = busy_obs(k);
        if (i < COL) begin o.wcen = 1'b0; o.waddr = ADDR_W'(i); end
        o.l0_wr = (i >= 1);
        if (e < MAXE) exp_a[e] = o;
      end
      for (int i = 0; i < ROW; i++) begin
        e++; o = busy_obs(k); o.load = 1'b1; o.l0_rd = 1'b1;
        if (e < MAXE) exp_a[e] = o;
      end
      for (int i = 0; i <= LEN_NIJ; i++) begin
        e++; o = busy_obs(k);
        if (i < LEN_NIJ) begin o.acen = 1'b0; o.aaddr = ADDR_W'(i); end
        o.mac = (i >= 1);
        if (e < MAXE) exp_a[e] = o;
      end
      pops = 0; writes = 0; pend = 1'b0;
      while (writes < LEN_ONIJ && e < MAXE - 1) begin
        e++; o = busy_obs(k);
        if (pend) begin
          o.pcen = 1'b0; o.pwen = 1'b0; o.paddr = ADDR_W'(k * LEN_ONIJ + writes); writes++;
        end
        pend = ov_a[e] && (pops < LEN_ONIJ);
        if (pend) begin o.ofifo_rd = 1'b1; pops++; end
        exp_a[e] = o;
      end
      e++; o = busy_obs(k);
      if (k < LEN_KIJ - 1) begin o.kij = 4'(k + 1); o.w_ready = 1'b1; end
      if (e < MAXE) exp_a[e] = o;
    end
    e++;
    if (e < MAXE) begin o = idle_obs(); o.done = 1'b1; exp_a[e] = o; done_e = e; end
    else done_e = -1;
  endtask

  task automatic clear_stim();
    for (int e = 0; e < MAXE; e++) begin
      st_a[e] = 1'b0; ab_a[e] = 1'b0; wv_a[e] = 1'b1; ov_a[e] = 1'b1;
      wd_a[e] = DW'($urandom); exp_a[e] = idle_obs(); act_a[e] = idle_obs();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0; ofifo_valid = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_edges(input int n);
    for (int e = 0; e < n && e < MAXE; e++) begin
      start = st_a[e]; abort = ab_a[e]; w_valid = wv_a[e]; w_data = wd_a[e]; ofifo_valid = ov_a[e];
      @(posedge clk); #1;
      act_a[e] = mask(sample());
    end
    start = 1'b0; abort = 1'b0; w_valid = 1'b0; ofifo_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0; ofifo_valid = 1'b0; w_data = '0;
    @(posedge clk); #1;
    o = sample();
    chk_cnt++;
    if (o !== idle_obs()) $display("FAIL reset_state got %h want %h", o, idle_obs());
    else pass_cnt++;
    #1 reset = 1'b0;
  endtask

  task automatic test_full_pass();
    int s, n, d, bad, dedge, nbusy0, nw, badc;
    int hits[NPSUM];
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    for (int i = 0; i < 4; i++) st_a[s + 1 + $urandom_range(0, 700)] = 1'b1;
    model(s, d); n = s + 730;
    run_edges(n);
    bad = first_diff(n);
    chk_cnt++;
    if (bad != -1) $display("FAIL full_trace edge %0d got %h want %h", bad, act_a[bad], mask(exp_a[bad]));
    else pass_cnt++;
    dedge = -1;
    for (int e = n - 1; e >= 0; e--) if (act_a[e].done) dedge = e;
    chk_cnt++;
    if (dedge - s !== 721) $display("FAIL done_latency got %0d want 721", dedge - s);
    else pass_cnt++;
    nbusy0 = 0;
    for (int e = s; e < s + 721; e++) if (!act_a[e].busy) nbusy0++;
    chk_cnt++;
    if (nbusy0 !== 0) $display("FAIL busy_held idle_edges %0d want 0", nbusy0);
    else pass_cnt++;
    foreach (hits[i]) hits[i] = 0;
    nw = 0;
    for (int e = 0; e < n; e++)
      if (!act_a[e].pcen && !act_a[e].pwen) begin
        nw++;
        if (act_a[e].paddr < ADDR_W'(NPSUM)) hits[act_a[e].paddr]++;
      end
    badc = 0;
    foreach (hits[i]) if (hits[i] != 1) badc++;
    chk_cnt++;
    if (nw !== NPSUM || badc !== 0) $display("FAIL psum_cover writes %0d bad_addrs %0d want %0d and 0", nw, badc, NPSUM);
    else pass_cnt++;
  endtask

  task automatic test_phase_timing();
    int s, nwr, nrd, bad, nl0, nld, nmac, fmac, a0, nexcl;
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    run_edges(s + 90);
    nwr = 0; bad = 0;
    for (int e = s; e <= s + 80; e++)
      if (!act_a[e].wcen && !act_a[e].wwen) begin
        if (act_a[e].waddr != ADDR_W'(nwr)) bad++;
        nwr++;
      end
    chk_cnt++;
    if (nwr !== COL || bad !== 0) $display("FAIL weight_write_addrs count %0d bad %0d want %0d and 0", nwr, bad, COL);
    else pass_cnt++;
    nl0 = 0; nrd = 0; bad = 0;
    for (int e = s + 1; e <= s + 80; e++) begin
      if (act_a[e].l0_wr) begin
        nl0++;
        if (!(act_a[e-1].wcen == 1'b0 && act_a[e-1].wwen == 1'b1)) bad++;
      end
      if (act_a[e].wcen == 1'b0 && act_a[e].wwen == 1'b1) begin
        nrd++;
        if (!act_a[e+1].l0_wr) bad++;
      end
    end
    chk_cnt++;
    if (nl0 !== COL || nrd !== COL || bad !== 0) $display("FAIL l0_wr_align l0 %0d reads %0d bad %0d want %0d %0d 0", nl0, nrd, bad, COL, COL);
    else pass_cnt++;
    nld = 0; bad = 0;
    for (int e = s; e <= s + 80; e++) begin
      if (act_a[e].load) nld++;
      if (act_a[e].load !== act_a[e].l0_rd) bad++;
    end
    chk_cnt++;
    if (nld !== ROW || bad !== 0) $display("FAIL pe_load count %0d bad %0d want %0d and 0", nld, bad, ROW);
    else pass_cnt++;
    nmac = 0; fmac = -1; a0 = -1; nexcl = 0;
    for (int e = s; e <= s + 80; e++) begin
      if (act_a[e].mac) begin nmac++; if (fmac < 0) fmac = e; end
      if (!act_a[e].acen && act_a[e].aaddr == '0 && a0 < 0) a0 = e;
      if (int'(act_a[e].l0_wr) + int'(act_a[e].load) + int'(act_a[e].mac) + int'(act_a[e].ofifo_rd) > 1) nexcl++;
    end
    chk_cnt++;
    if (nmac !== LEN_NIJ || a0 < 0 || fmac !== a0 + 1) $display("FAIL mac_timing count %0d first %0d act0 %0d want %0d and act0+1", nmac, fmac, a0, LEN_NIJ);
    else pass_cnt++;
    chk_cnt++;
    if (nexcl !== 0) $display("FAIL strobe_exclusive edges %0d want 0", nexcl);
    else pass_cnt++;
  endtask

  task automatic test_wvalid_toggle();
    int s, d, n, bad, nw, badd;
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    for (int e = s + 1; e < MAXE; e++) wv_a[e] = ((e - s) % 2 == 1);
    model(s, d); n = (d < 0) ? MAXE : d + 3;
    run_edges(n);
    bad = first_diff(n);
    chk_cnt++;
    if (bad != -1) $display("FAIL toggle_trace edge %0d got %h want %h", bad, act_a[bad], mask(exp_a[bad]));
    else pass_cnt++;
    nw = 0; badd = 0;
    for (int e = 0; e < n; e++)
      if (!act_a[e].wcen && !act_a[e].wwen) begin
        nw++;
        if (act_a[e].wdata !== wd_a[e] || !wv_a[e]) badd++;
      end
    chk_cnt++;
    if (nw !== COL * LEN_KIJ || badd !== 0) $display("FAIL toggle_words count %0d bad_data %0d want %0d and 0", nw, badd, COL * LEN_KIJ);
    else pass_cnt++;
  endtask

  task automatic test_drain_stall();
    int s, d, n, bad, nhold, nw, badw, fw;
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    for (int e = s + 63; e <= s + 112; e++) ov_a[e] = 1'b0;
    model(s, d); n = (d < 0) ? MAXE : d + 3;
    run_edges(n);
    bad = first_diff(n);
    chk_cnt++;
    if (bad != -1) $display("FAIL stall_trace edge %0d got %h want %h", bad, act_a[bad], mask(exp_a[bad]));
    else pass_cnt++;
    nhold = 0;
    for (int e = s + 63; e <= s + 112; e++) if (act_a[e].ofifo_rd || !act_a[e].pcen) nhold++;
    chk_cnt++;
    if (nhold !== 0) $display("FAIL stall_quiet active_edges %0d want 0", nhold);
    else pass_cnt++;
    nw = 0; badw = 0; fw = -1;
    for (int e = s; e < n && nw < LEN_ONIJ; e++)
      if (!act_a[e].pcen && !act_a[e].pwen) begin
        if (fw < 0) fw = e;
        if (act_a[e].paddr != ADDR_W'(nw)) badw++;
        nw++;
      end
    chk_cnt++;
    if (nw !== LEN_ONIJ || badw !== 0 || fw <= s + 112) $display("FAIL stall_writes count %0d bad %0d first %0d want %0d 0 >%0d", nw, badw, fw, LEN_ONIJ, s + 112);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int s, a, s2, d, d2, n, bad, nd, dedge;
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    a = s + 3 * 80 + 40; ab_a[a] = 1'b1;
    s2 = a + 5; st_a[s2] = 1'b1;
    model(s, d);
    for (int e = a; e < MAXE; e++) exp_a[e] = idle_obs();
    model(s2, d2); n = (d2 < 0) ? MAXE : d2 + 3;
    run_edges(n);
    bad = first_diff(n);
    chk_cnt++;
    if (bad != -1) $display("FAIL abort_trace edge %0d got %h want %h", bad, act_a[bad], mask(exp_a[bad]));
    else pass_cnt++;
    chk_cnt++;
    if (act_a[a-1].kij !== 4'd3 || act_a[a-1].mac !== 1'b1) $display("FAIL abort_in_exec kij %0d mac %0b want 3 and 1", act_a[a-1].kij, act_a[a-1].mac);
    else pass_cnt++;
    chk_cnt++;
    if (act_a[a] !== idle_obs()) $display("FAIL abort_edge got %h want %h", act_a[a], idle_obs());
    else pass_cnt++;
    nd = 0; dedge = -1;
    for (int e = 0; e < n; e++) if (act_a[e].done) begin nd++; dedge = e; end
    chk_cnt++;
    if (nd !== 1 || dedge - s2 !== 721) $display("FAIL abort_restart done_pulses %0d latency %0d want 1 and 721", nd, dedge - s2);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int s, d, n, bad, nw, badc;
    int hits[NPSUM];
    do_reset(); clear_stim();
    s = 3; st_a[s] = 1'b1;
    for (int e = s + 1; e < MAXE; e++) begin
      wv_a[e] = ($urandom_range(0, 99) < 60);
      ov_a[e] = ($urandom_range(0, 99) < 60);
    end
    model(s, d); n = (d < 0) ? MAXE : d + 3;
    if (d > s + 2) for (int i = 0; i < 6; i++) st_a[s + 1 + $urandom_range(0, d - s - 2)] = 1'b1;
    run_edges(n);
    bad = first_diff(n);
    chk_cnt++;
    if (bad != -1) $display("FAIL random_trace edge %0d got %h want %h", bad, act_a[bad], mask(exp_a[bad]));
    else pass_cnt++;
    foreach (hits[i]) hits[i] = 0;
    nw = 0;
    for (int e = 0; e < n; e++)
      if (!act_a[e].pcen && !act_a[e].pwen) begin
        nw++;
        if (act_a[e].paddr < ADDR_W'(NPSUM)) hits[act_a[e].paddr]++;
      end
    badc = 0;
    foreach (hits[i]) if (hits[i] != 1) badc++;
    chk_cnt++;
    if (nw !== NPSUM || badc !== 0) $display("FAIL random_psum writes %0d bad_addrs %0d want %0d and 0", nw, badc, NPSUM);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int s;
    obs_t o;
    do_reset(); clear_stim();
    s = 2; st_a[s] = 1'b1;
    run_edges(s + 21);
    chk_cnt++;
    if (act_a[s + 20].load !== 1'b1) $display("FAIL in_peload load %0b want 1", act_a[s + 20].load);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1 o = sample();
    chk_cnt++;
    if (o !== idle_obs()) $display("FAIL async_reset got %h want %h", o, idle_obs());
    else pass_cnt++;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 o = sample();
    chk_cnt++;
    if (o !== idle_obs()) $display("FAIL start_in_reset got %h want %h", o, idle_obs());
    else pass_cnt++;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1 o = sample();
    chk_cnt++;
    if (o !== idle_obs()) $display("FAIL after_release got %h want %h", o, idle_obs());
    else pass_cnt++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_pass();
    test_phase_timing();
    test_wvalid_toggle();
    test_drain_stall();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Sequencer that drives one core through a full convolution pass, one kernel position (kij) after another.
- Per kij it runs six phases in order: weight-SRAM fill from a host stream, weight SRAM to L0, L0 to PE load, execute over activation SRAM, OFIFO drain into psum SRAM, advance kij.
- Replaces hand-timed stimulus with a single start/done interface.
- Sits between the host/testbench and the core control pins.

Parameters:
- BW, 4, activation/weight bit width
- ROW, 8, PE rows (weight words loaded into PEs)
- COL, 8, weight words per kij
- LEN_KIJ, 9, kernel positions per pass
- LEN_NIJ, 36, activation words per execute phase
- LEN_ONIJ, 16, output words drained per kij
- ADDR_W, 11, SRAM address width; LEN_KIJ*LEN_ONIJ must be < 2^ADDR_W

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin pass; sampled only in IDLE
- abort  in  1  synchronous return to IDLE
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse at pass end
- kij  out  4  current kernel position
- w_valid  in  1  host weight word valid
- w_ready  out  1  controller accepts a weight word
- w_data  in  BW*ROW  host weight word
- weight_data_in  out  BW*ROW  registered w_data to weight SRAM
- weight_sram_cen  out  1  active-low
- weight_sram_wen  out  1  active-low
- weight_addr  out  ADDR_W  weight SRAM address
- l0_wr  out  1  L0 write strobe
- l0_rd  out  1  L0 read strobe
- load  out  1  PE weight-load enable
- mac_array_en  out  1  execute enable
- act_sram_cen  out  1  active-low
- act_sram_wen  out  1  active-low
- act_addr  out  ADDR_W  activation SRAM address
- ofifo_valid  in  1  OFIFO has data
- ofifo_rd  out  1  OFIFO pop
- psum_sram_cen  out  1  active-low
- psum_sram_wen  out  1  active-low
- psum_addr  out  ADDR_W  psum SRAM address

Behaviour:
- Reset values: all cen/wen = 1; all strobes, busy, done, w_ready = 0; all addresses, kij and weight_data_in = 0; state IDLE. Reset is asynchronous and takes effect immediately, mid-operation included.
- All outputs are registered.
- Cycle n below means the nth clk edge after the phase is entered.
- IDLE: start=1 at an edge moves to WLOAD and sets busy=1 on that edge. start is ignored while busy.
- WLOAD:
  - w_ready=1.
  - Each edge with w_valid&w_ready writes one word: weight_sram_cen=0, wen=0, weight_addr=t, weight_data_in=w_data, t = 0..COL-1.
  - w_valid low stalls the phase with cen=1 and no penalty.
  - After COL accepted words, w_ready drops and the state moves to L0WR.
- L0WR (COL+1 cycles):
  - Cycles 0..COL-1: weight read with cen=0, wen=1, addr 0..COL-1.
  - l0_wr=1 in cycles 1..COL, aligned to the 1-cycle SRAM read latency.
- PELOAD (ROW cycles): load=1 and l0_rd=1 throughout.
- EXEC (LEN_NIJ+1 cycles):
  - Cycles 0..LEN_NIJ-1: act read with cen=0, wen=1, act_addr 0..LEN_NIJ-1.
  - mac_array_en=1 in cycles 1..LEN_NIJ.
- DRAIN:
  - ofifo_rd=1 in any cycle where ofifo_valid=1 and pops < LEN_ONIJ.
  - The cycle after each pop: psum_sram_cen=0, wen=0, psum_addr = kij*LEN_ONIJ + write_count.
  - Exit after LEN_ONIJ writes. No timeout: the phase waits indefinitely for ofifo_valid.
- NEXT (1 cycle):
  - If kij == LEN_KIJ-1: go to DONE.
  - Otherwise kij increments and the state returns to WLOAD.
- DONE (1 cycle): done=1, busy=0, kij=0, then IDLE.
- abort=1 at any edge outside IDLE:
  - Next state is IDLE.
  - All strobes, cen and wen return to reset values on that edge; kij=0.
  - done is not pulsed.
  - abort has priority over start and over phase transitions.
- Strobe exclusivity: at most one of l0_wr, load, mac_array_en, ofifo_rd is high in any cycle.
- Nominal cost per kij with no stalls and ofifo_valid always 1: 8+9+8+37+17+1 = 80 cycles. A full pass is 721 cycles after start.

Test Plan:
1. Reset, start pulse, w_valid held 1, ofifo_valid held 1:
   - done asserts exactly 721 cycles after start.
   - busy stays high throughout.
   - 144 psum writes, addresses 0..143, each exactly once.
2. Single kij, check phase timing:
   - Weight writes to addresses 0..7.
   - l0_wr high for 8 cycles, exactly one cycle behind the weight read cen.
   - load/l0_rd high for 8 cycles.
   - mac_array_en high for 36 cycles, one cycle behind act_addr 0.
3. w_valid toggled 1,0,1,0…:
   - Exactly 8 words written per kij; w_ready low outside WLOAD.
   - weight_data_in matches the accepted w_data sequence.
4. ofifo_valid held 0 for 50 cycles in DRAIN, then 1:
   - No ofifo_rd or psum writes during the hold.
   - Then 16 pops and writes at kij*16+0..15.
5. abort during kij=3 EXEC:
   - Next edge all strobes 0, cen/wen=1, busy=0, kij=0, no done.
   - A fresh start restarts at kij=0.
6. reset asserted mid-PELOAD (between edges):
   - Outputs reach reset values immediately, without waiting for clk.
   - start during busy and start while reset=1 are both ignored.
